// File: rtl/display_mux_scheduler_pkg.sv
// Shared types and helpers for the dual seven-segment display scheduler.
//   disp_state_t : scheduler FSM states (blanking interval / digit show slot)
//   NUM_DIGITS   : number of multiplexed digits
//   hex_t        : one hex nibble as presented to the segment decoder
//   onehot2()    : digit index -> active-high digit-select pattern
package disp_pkg;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } disp_state_t;

    localparam int NUM_DIGITS = 2;

    typedef logic [3:0] hex_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/display_mux_scheduler_if.sv
// Connection bundle between the nibble sources / segment decoder and the
// display scheduler.
//   dwell      : show time per digit, in cycles minus one
//   digit0/1   : hex nibbles for the left / right digit
//   digit_en   : per-digit enable, bit i = 0 keeps digit i dark
//   hex_out    : nibble to the shared segment decoder
//   seg_blank  : 1 forces the decoder outputs off
//   sel        : one-hot active-high digit drive, 00 while blanking
//   frame_tick : one-cycle pulse after each digit1 show slot
// master = the surrounding system, slave = the scheduler.
interface display_mux_scheduler_if
    import disp_pkg::*;
#(
    parameter int DWELL_W = 20
);
    logic [DWELL_W-1:0]    dwell;
    hex_t                  digit0;
    hex_t                  digit1;
    logic [NUM_DIGITS-1:0] digit_en;
    hex_t                  hex_out;
    logic                  seg_blank;
    logic [NUM_DIGITS-1:0] sel;
    logic                  frame_tick;

    modport master (
        output dwell, digit0, digit1, digit_en,
        input  hex_out, seg_blank, sel, frame_tick
    );

    modport slave (
        input  dwell, digit0, digit1, digit_en,
        output hex_out, seg_blank, sel, frame_tick
    );
endinterface

// File: rtl/display_mux_scheduler_counter.sv
// Loadable down-counter shared by the blanking and show phases.
//   clk, reset : clock and synchronous active-high reset (loads RST_VAL)
//   load       : load load_val on the next edge instead of decrementing
//   load_val   : reload value
//   zero       : count is at zero (terminal count of the current phase)
module disp_down_counter #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/display_mux_scheduler.sv
// Time-multiplexing scheduler for the dual seven-segment display. Alternates
// the shared hex decoder between digit0 and digit1 and inserts a blanking
// interval of BLANK_CYCLES at every digit switch to suppress ghosting.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : display_mux_scheduler_if slave (inputs nibbles/enables/dwell,
//           outputs hex_out/seg_blank/sel/frame_tick, all registered)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_BLANK | all digits off, decoder blanked; counting BLANK_CYCLES
// S_SHOW  | digit[ptr] driven with values captured at entry; counting dwell+1
module display_mux_scheduler
    import disp_pkg::*;
#(
    parameter int DWELL_W      = 20,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 20
) (
    input logic                   clk,
    input logic                   reset,
    display_mux_scheduler_if.slave bus
);

    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("display_mux_scheduler: BLANK_CYCLES must be at least 1");
    end
    if (CNT_W < DWELL_W) begin : g_chk_dwell_w
        $error("display_mux_scheduler: CNT_W cannot hold the maximum dwell");
    end
    if (((longint'(BLANK_CYCLES) - 1) >> CNT_W) != 0) begin : g_chk_blank_w
        $error("display_mux_scheduler: CNT_W cannot hold BLANK_CYCLES-1");
    end

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    disp_state_t      state;
    logic             ptr;
    hex_t             hex_q;
    logic             blank_q;
    logic [1:0]       sel_q;
    logic             tick_q;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;
    hex_t             cur_hex;
    logic             cur_en;

    // The counter reloads on every terminal count; what it reloads with
    // depends on which phase is ending (blank -> dwell, show -> blank length).
    always_comb begin
        load_val = BLANK_LOAD;
        if (state == S_BLANK) begin
            load_val = CNT_W'(bus.dwell);
        end
    end

    disp_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (BLANK_LOAD)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_zero),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    assign cur_hex = ptr ? bus.digit1 : bus.digit0;
    assign cur_en  = bus.digit_en[ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_BLANK;
            ptr     <= 1'b0;
            hex_q   <= '0;
            blank_q <= 1'b1;
            sel_q   <= 2'b00;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                S_BLANK: begin
                    if (cnt_zero) begin
                        state   <= S_SHOW;
                        hex_q   <= cur_hex;
                        sel_q   <= cur_en ? onehot2(ptr) : 2'b00;
                        blank_q <= ~cur_en;
                    end
                end
                S_SHOW: begin
                    if (cnt_zero) begin
                        state   <= S_BLANK;
                        sel_q   <= 2'b00;
                        blank_q <= 1'b1;
                        ptr     <= ~ptr;
                        // Leaving the digit1 slot closes a frame.
                        tick_q  <= ptr;
                    end
                end
                default: begin
                    state <= S_BLANK;
                end
            endcase
        end
    end

    assign bus.hex_out    = hex_q;
    assign bus.seg_blank  = blank_q;
    assign bus.sel        = sel_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_scheduler.sv
module tb_display_mux_scheduler;
    import disp_pkg::*;

    localparam int B  = 4;
    localparam int DW = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    display_mux_scheduler_if #(.DWELL_W(DW)) bus ();

    display_mux_scheduler #(
        .DWELL_W      (DW),
        .BLANK_CYCLES (B),
        .CNT_W        (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Phase model: 0 blank before digit0, 1 digit0 show, 2 blank before
    // digit1, 3 digit1 show. m_left counts cycles remaining in the phase.
    int         m_phase;
    int         m_left;
    logic [3:0] m_hex;
    logic [1:0] m_sel;
    logic       m_blank;
    logic       m_tick;

    task automatic advance();
        int idx;
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_left = B; m_hex = 4'h0;
            m_sel = 2'b00; m_blank = 1'b1; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_phase = (m_phase + 1) % 4;
                if (m_phase == 1 || m_phase == 3) begin
                    idx     = (m_phase == 3) ? 1 : 0;
                    m_left  = int'(bus.dwell) + 1;
                    m_hex   = idx ? bus.digit1 : bus.digit0;
                    m_sel   = bus.digit_en[idx] ? (idx ? 2'b10 : 2'b01) : 2'b00;
                    m_blank = ~bus.digit_en[idx];
                end else begin
                    m_left  = B;
                    m_sel   = 2'b00;
                    m_blank = 1'b1;
                    m_tick  = (m_phase == 0);
                end
            end
        end
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.dwell = 20'd9; bus.digit0 = 4'h3; bus.digit1 = 4'hA; bus.digit_en = 2'b11;
        reset = 1'b1;
        repeat (3) advance();
        n_cmp++; if (bus.sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel got=%b exp=00", bus.sel); end
        n_cmp++; if (bus.seg_blank !== 1'b1) begin n_bad++; $display("FAIL reset_blank got=%b exp=1", bus.seg_blank); end
        n_cmp++; if (bus.hex_out !== 4'h0) begin n_bad++; $display("FAIL reset_hex got=%h exp=0", bus.hex_out); end
        n_cmp++; if (bus.frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_schedule();
        int t1 = -1, t2 = -1;
        repeat (56) begin
            advance();
            n_cmp++;
            if ({bus.hex_out, bus.sel, bus.seg_blank, bus.frame_tick} !== {m_hex, m_sel, m_blank, m_tick}) begin
                n_bad++;
                $display("FAIL sched cyc=%0d got hex=%h sel=%b blank=%b tick=%b exp hex=%h sel=%b blank=%b tick=%b",
                         cyc, bus.hex_out, bus.sel, bus.seg_blank, bus.frame_tick, m_hex, m_sel, m_blank, m_tick);
            end
            if (cyc == 4 || cyc == 13) begin
                n_cmp++;
                if ({bus.sel, bus.hex_out} !== {2'b01, 4'h3}) begin n_bad++; $display("FAIL sched_d0 cyc=%0d got sel=%b hex=%h exp sel=01 hex=3", cyc, bus.sel, bus.hex_out); end
            end
            if (cyc == 14 || cyc == 17) begin
                n_cmp++;
                if ({bus.sel, bus.seg_blank} !== {2'b00, 1'b1}) begin n_bad++; $display("FAIL sched_gap cyc=%0d got sel=%b blank=%b exp sel=00 blank=1", cyc, bus.sel, bus.seg_blank); end
            end
            if (cyc == 18 || cyc == 27) begin
                n_cmp++;
                if ({bus.sel, bus.hex_out} !== {2'b10, 4'hA}) begin n_bad++; $display("FAIL sched_d1 cyc=%0d got sel=%b hex=%h exp sel=10 hex=a", cyc, bus.sel, bus.hex_out); end
            end
            if (bus.frame_tick === 1'b1) begin
                if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
            end
        end
        n_cmp++; if (t1 != 28) begin n_bad++; $display("FAIL sched_tick1 got=%0d exp=28", t1); end
        n_cmp++; if (t2 != 56) begin n_bad++; $display("FAIL sched_tick2 got=%0d exp=56", t2); end
    endtask

    task automatic test_digit_change();
        while (cyc < 66) begin
            advance();
            n_cmp++; if (bus.hex_out !== m_hex) begin n_bad++; $display("FAIL chg_hex cyc=%0d got=%h exp=%h", cyc, bus.hex_out, m_hex); end
        end
        bus.digit0 = 4'h7;
        while (cyc < 112) begin
            advance();
            n_cmp++; if (bus.hex_out !== m_hex) begin n_bad++; $display("FAIL chg_hex cyc=%0d got=%h exp=%h", cyc, bus.hex_out, m_hex); end
            if (cyc == 73) begin
                n_cmp++; if (bus.hex_out !== 4'h3) begin n_bad++; $display("FAIL chg_hold got=%h exp=3", bus.hex_out); end
            end
            if (cyc == 92) begin
                n_cmp++; if (bus.hex_out !== 4'h7) begin n_bad++; $display("FAIL chg_new got=%h exp=7", bus.hex_out); end
            end
        end
    endtask

    task automatic test_enable();
        int t1 = -1, t2 = -1;
        bus.digit_en = 2'b10;
        while (cyc < 168) begin
            advance();
            n_cmp++;
            if ({bus.sel, bus.seg_blank} !== {m_sel, m_blank}) begin
                n_bad++; $display("FAIL en cyc=%0d got sel=%b blank=%b exp sel=%b blank=%b", cyc, bus.sel, bus.seg_blank, m_sel, m_blank);
            end
            if (cyc == 120) begin
                n_cmp++; if ({bus.sel, bus.seg_blank} !== 3'b001) begin n_bad++; $display("FAIL en_d0_dark got sel=%b blank=%b exp sel=00 blank=1", bus.sel, bus.seg_blank); end
            end
            if (cyc == 134) begin
                n_cmp++; if ({bus.sel, bus.seg_blank} !== 3'b100) begin n_bad++; $display("FAIL en_d1_lit got sel=%b blank=%b exp sel=10 blank=0", bus.sel, bus.seg_blank); end
            end
            if (bus.frame_tick === 1'b1) begin
                if (t1 < 0) t1 = cyc; else if (t2 < 0) t2 = cyc;
            end
        end
        n_cmp++; if (t1 != 140) begin n_bad++; $display("FAIL en_tick1 got=%0d exp=140", t1); end
        n_cmp++; if (t2 != 168) begin n_bad++; $display("FAIL en_tick2 got=%0d exp=168", t2); end
        bus.digit_en = 2'b11;
    endtask

    task automatic test_dwell0();
        int first = -1, ticks = 0;
        bus.dwell = 20'd0;
        while (cyc < 1168) begin
            advance();
            n_cmp++; if (bus.sel === 2'b11) begin n_bad++; $display("FAIL d0_sel11 cyc=%0d got=%b exp=not 11", cyc, bus.sel); end
            n_cmp++; if (bus.seg_blank === 1'b1 && bus.sel !== 2'b00) begin n_bad++; $display("FAIL d0_lit_blank cyc=%0d got sel=%b blank=1 exp sel=00", cyc, bus.sel); end
            n_cmp++;
            if ({bus.sel, bus.seg_blank, bus.frame_tick} !== {m_sel, m_blank, m_tick}) begin
                n_bad++; $display("FAIL d0_sched cyc=%0d got sel=%b blank=%b tick=%b exp sel=%b blank=%b tick=%b",
                                  cyc, bus.sel, bus.seg_blank, bus.frame_tick, m_sel, m_blank, m_tick);
            end
            if (bus.frame_tick === 1'b1) begin
                ticks++;
                if (first < 0) first = cyc;
            end
        end
        n_cmp++; if (first != 178) begin n_bad++; $display("FAIL d0_first_tick got=%0d exp=178", first); end
        n_cmp++; if (ticks != 100) begin n_bad++; $display("FAIL d0_tick_count got=%0d exp=100", ticks); end
    endtask

    task automatic test_reset_mid();
        bus.dwell = 20'd9;
        while (cyc < 1195) begin
            advance();
            n_cmp++;
            if ({bus.hex_out, bus.sel, bus.seg_blank, bus.frame_tick} !== {m_hex, m_sel, m_blank, m_tick}) begin
                n_bad++; $display("FAIL rmid_pre cyc=%0d got hex=%h sel=%b exp hex=%h sel=%b", cyc, bus.hex_out, bus.sel, m_hex, m_sel);
            end
        end
        n_cmp++; if (bus.sel !== 2'b10) begin n_bad++; $display("FAIL rmid_in_d1 got=%b exp=10", bus.sel); end
        // Last cycle of the digit1 slot: reset must beat the frame-end transition.
        reset = 1'b1;
        advance();
        n_cmp++; if (bus.sel !== 2'b00) begin n_bad++; $display("FAIL rmid_sel got=%b exp=00", bus.sel); end
        n_cmp++; if (bus.seg_blank !== 1'b1) begin n_bad++; $display("FAIL rmid_blank got=%b exp=1", bus.seg_blank); end
        n_cmp++; if (bus.hex_out !== 4'h0) begin n_bad++; $display("FAIL rmid_hex got=%h exp=0", bus.hex_out); end
        n_cmp++; if (bus.frame_tick !== 1'b0) begin n_bad++; $display("FAIL rmid_tick got=%b exp=0", bus.frame_tick); end
        reset = 1'b0;
        cyc = 0;
        while (cyc < 14) begin
            advance();
            n_cmp++;
            if ({bus.hex_out, bus.sel, bus.seg_blank, bus.frame_tick} !== {m_hex, m_sel, m_blank, m_tick}) begin
                n_bad++; $display("FAIL rmid_post cyc=%0d got hex=%h sel=%b exp hex=%h sel=%b", cyc, bus.hex_out, bus.sel, m_hex, m_sel);
            end
            if (cyc == 3) begin
                n_cmp++; if ({bus.sel, bus.seg_blank} !== 3'b001) begin n_bad++; $display("FAIL rmid_blank3 got sel=%b blank=%b exp sel=00 blank=1", bus.sel, bus.seg_blank); end
            end
            if (cyc == 4) begin
                n_cmp++; if ({bus.sel, bus.hex_out} !== {2'b01, 4'h7}) begin n_bad++; $display("FAIL rmid_restart got sel=%b hex=%h exp sel=01 hex=7", bus.sel, bus.hex_out); end
            end
        end
    endtask

    task automatic test_dwell_change();
        while (cyc < 22) begin
            advance();
            n_cmp++; if (bus.sel !== m_sel) begin n_bad++; $display("FAIL dchg_pre cyc=%0d got=%b exp=%b", cyc, bus.sel, m_sel); end
        end
        bus.dwell = 20'd2;
        while (cyc < 60) begin
            advance();
            n_cmp++;
            if ({bus.sel, bus.seg_blank, bus.frame_tick} !== {m_sel, m_blank, m_tick}) begin
                n_bad++; $display("FAIL dchg cyc=%0d got sel=%b tick=%b exp sel=%b tick=%b", cyc, bus.sel, bus.frame_tick, m_sel, m_tick);
            end
            case (cyc)
                27, 39, 41: begin
                    n_cmp++; if (bus.sel !== 2'b10) begin n_bad++; $display("FAIL dchg_d1 cyc=%0d got=%b exp=10", cyc, bus.sel); end
                end
                32, 34: begin
                    n_cmp++; if (bus.sel !== 2'b01) begin n_bad++; $display("FAIL dchg_d0 cyc=%0d got=%b exp=01", cyc, bus.sel); end
                end
                35: begin
                    n_cmp++; if (bus.sel !== 2'b00) begin n_bad++; $display("FAIL dchg_short cyc=%0d got=%b exp=00", cyc, bus.sel); end
                end
                28, 42: begin
                    n_cmp++; if ({bus.sel, bus.frame_tick} !== 3'b001) begin n_bad++; $display("FAIL dchg_end cyc=%0d got sel=%b tick=%b exp sel=00 tick=1", cyc, bus.sel, bus.frame_tick); end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_digit_change();
        test_enable();
        test_dwell0();
        test_reset_mid();
        test_dwell_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
